register_window_controller: RTL
===============================

// Module: register_window_controller
// PURPOSE
//  Sequences sr_value (current window pointer, CWP) for address_generation_unit on call/ret.
//  Owns a 16-entry circular register-window file.
//  - On overflow: spills the oldest window to a data-memory spill stack.
//  - On underflow: fills the window back from that stack.
//  - Stalls the core (busy) while a spill or fill runs.
// PARAMETERS
//  WIN_REGS   8    registers per window moved on spill/fill (<=16, power of 2)
//  MAX_SPILL  32   spill-stack capacity in windows (power of 2)
//  MEM_AW     8    mem_addr width = log2(MAX_SPILL*WIN_REGS)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous reset, active high
//  call_req     in   1       core: enter new window (1-cycle pulse)
//  ret_req      in   1       core: return to previous window (1-cycle pulse)
//  busy         out  1       core stall
//  sr_value     out  4       window select to AGU
//  xfer_active  out  1       1 = AGU local addresses overridden by xfer_laddr
//  xfer_laddr   out  4       local register index during spill/fill (zero-extended idx)
//  rf_fill_we   out  1       RF write strobe for fill data (= mem_ack in FILL)
//  mem_req      out  1       memory request
//  mem_we       out  1       1 = spill write, 0 = fill read
//  mem_addr     out  MEM_AW  {depth, idx}
//  mem_ack      in   1       memory accept; read data valid in the same cycle
//  err          out  2       sticky: 01 spill-stack full, 10 underflow, 11 call+ret together
// BEHAVIOUR
//  - State: cwp[3:0], res_cnt[4:0] (1..16 resident windows), depth (0..MAX_SPILL), idx, FSM.
//  - FSM states: IDLE, SPILL, FILL.
//  - Reset values: cwp=0, res_cnt=1, depth=0, idx=0, IDLE, mem_req=0, err=00.
//  - sr_value: cwp in IDLE; victim (cwp+1) in SPILL; cwp-1 in FILL.
//  - Requests are sampled only in IDLE; requests while state!=IDLE are ignored.
//  - call, res_cnt<16: next edge cwp+=1, res_cnt+=1. Zero latency; busy stays 0.
//  - call, res_cnt==16, depth<MAX: busy=1 combinationally; go to SPILL.
//  - call, res_cnt==16, depth==MAX: no state change; err|=01.
//  - ret, res_cnt>1: next edge cwp-=1, res_cnt-=1.
//  - ret, res_cnt==1, depth>0: busy=1 combinationally; go to FILL.
//  - ret, res_cnt==1, depth==0: no state change; err|=10.
//  - call and ret in the same cycle: both ignored; err|=11.
//  - SPILL: mem_req=1, mem_we=1, mem_addr={depth,idx}, xfer_laddr=idx.
//    RF port-A data feeds memory write data outside this block.
//  - FILL: mem_req=1, mem_we=0, mem_addr={depth-1,idx}.
//    rf_fill_we=mem_ack; write address via xfer_laddr.
//  - Handshake: mem_req, mem_we and mem_addr stay stable until mem_ack.
//    Each ack advances idx; mem_ack ignored when mem_req=0.
//  - SPILL done (ack at idx=WIN_REGS-1): depth+=1; cwp+=1; res_cnt unchanged.
//    Then IDLE; mem_req=0 next cycle.
//  - FILL done (ack at idx=WIN_REGS-1): depth-=1; cwp-=1; res_cnt stays 1. Then IDLE.
//  - busy = (state!=IDLE) | (IDLE & request that needs spill/fill).
//  - cwp wraps modulo 16.
//  - Reset mid-transfer: full reset at that edge; partial spill discarded.
// CONFIGURATION
//  WIN_STATS_EN defined:
//   - Adds outputs spill_cnt[15:0] and fill_cnt[15:0].
//   - Each counts completed spills/fills, saturating at 16'hFFFF; reset to 0.
//  WIN_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset; 3 calls -> sr_value 0,1,2,3; busy never 1; err=00
//  2 reset; 16 calls, mem_ack tied 1 -> 16th call spills window 0:
//    mem_addr 0..7 we=1; then sr_value=0, depth=1
//  3 after test 2; 16 rets -> last ret fills window 0 from mem_addr 0..7 (8 rf_fill_we);
//    sr_value=0, depth=0
//  4 reset; ret -> err=10, sr_value=0; then call+ret same cycle -> err=11, sr_value=0
//  5 spill with mem_ack delayed 3 cycles per beat -> mem_req/mem_addr/xfer_laddr held stable;
//    busy spans the whole spill
//  6 reset asserted after 3 spill acks -> next cycle mem_req=0, busy=0, sr_value=0, err=00

Source files
------------

// File: rtl/register_window_controller.sv
// Current-window-pointer sequencer for a 16-entry circular register-window file.
// Spills/fills windows to a memory stack; define WIN_STATS_EN for spill/fill counters.
module register_window_controller #(
  parameter int unsigned WIN_REGS  = 8,
  parameter int unsigned MAX_SPILL = 32,
  parameter int unsigned MEM_AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              ret_req,
  output logic              busy,
  output logic [3:0]        sr_value,
  output logic              xfer_active,
  output logic [3:0]        xfer_laddr,
  output logic              rf_fill_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [1:0]        err
`ifdef WIN_STATS_EN
  ,
  output logic [15:0]       spill_cnt,
  output logic [15:0]       fill_cnt
`endif
);

  localparam int unsigned IDX_W   = $clog2(WIN_REGS);
  localparam int unsigned PTR_W   = $clog2(MAX_SPILL);
  localparam int unsigned DEPTH_W = PTR_W + 1;
  localparam int unsigned RES_W   = 5;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cwp_q, cwp_d;
  logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         err_q, err_d;
  logic               start_xfer;
  logic               last_beat;
  logic [PTR_W-1:0]   slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cwp_q     <= '0;
      res_cnt_q <= RES_W'(1);
      depth_q   <= '0;
      idx_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cwp_q     <= cwp_d;
      res_cnt_q <= res_cnt_d;
      depth_q   <= depth_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  assign last_beat = (idx_q == IDX_W'(WIN_REGS - 1));

  always_comb begin
    state_d    = state_q;
    cwp_d      = cwp_q;
    res_cnt_d  = res_cnt_q;
    depth_d    = depth_q;
    idx_d      = idx_q;
    err_d      = err_q;
    start_xfer = 1'b0;
    case (state_q)
      IDLE: begin
        if (call_req && ret_req) begin
          err_d = 2'b11;
        end else if (call_req) begin
          if (res_cnt_q != RES_W'(16)) begin
            cwp_d     = cwp_q + 4'd1;
            res_cnt_d = res_cnt_q + RES_W'(1);
          end else if (depth_q != DEPTH_W'(MAX_SPILL)) begin
            state_d    = SPILL;
            start_xfer = 1'b1;
          end else begin
            err_d = err_q | 2'b01;
          end
        end else if (ret_req) begin
          if (res_cnt_q != RES_W'(1)) begin
            cwp_d     = cwp_q - 4'd1;
            res_cnt_d = res_cnt_q - RES_W'(1);
          end else if (depth_q != '0) begin
            state_d    = FILL;
            start_xfer = 1'b1;
          end else begin
            err_d = err_q | 2'b10;
          end
        end
      end
      SPILL: begin
        if (mem_ack) begin
          idx_d = idx_q + IDX_W'(1);
          if (last_beat) begin
            idx_d   = '0;
            depth_d = depth_q + DEPTH_W'(1);
            cwp_d   = cwp_q + 4'd1;
            state_d = IDLE;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          idx_d = idx_q + IDX_W'(1);
          if (last_beat) begin
            idx_d   = '0;
            depth_d = depth_q - DEPTH_W'(1);
            cwp_d   = cwp_q - 4'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer outputs: spill targets the oldest window (cwp+1), fill restores cwp-1
  always_comb begin
    busy        = 1'b0;
    sr_value    = cwp_q;
    xfer_active = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rf_fill_we  = 1'b0;
    slot        = '0;
    case (state_q)
      IDLE: busy = start_xfer;
      SPILL: begin
        busy        = 1'b1;
        sr_value    = cwp_q + 4'd1;
        xfer_active = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        slot        = depth_q[PTR_W-1:0];
      end
      FILL: begin
        busy        = 1'b1;
        sr_value    = cwp_q - 4'd1;
        xfer_active = 1'b1;
        mem_req     = 1'b1;
        rf_fill_we  = mem_ack;
        slot        = PTR_W'(depth_q - DEPTH_W'(1));
      end
      default: busy = 1'b0;
    endcase
  end

  assign mem_addr   = MEM_AW'({slot, idx_q});
  assign xfer_laddr = 4'(idx_q);
  assign err        = err_q;

`ifdef WIN_STATS_EN
  logic        spill_done, fill_done;
  logic [15:0] spill_cnt_q, fill_cnt_q;

  assign spill_done = (state_q == SPILL) && mem_ack && last_beat;
  assign fill_done  = (state_q == FILL) && mem_ack && last_beat;

  // Saturating completion counters
  always_ff @(posedge clk) begin
    if (reset) begin
      spill_cnt_q <= '0;
      fill_cnt_q  <= '0;
    end else begin
      if (spill_done && (spill_cnt_q != 16'hFFFF)) spill_cnt_q <= spill_cnt_q + 16'd1;
      if (fill_done && (fill_cnt_q != 16'hFFFF))   fill_cnt_q  <= fill_cnt_q + 16'd1;
    end
  end

  assign spill_cnt = spill_cnt_q;
  assign fill_cnt  = fill_cnt_q;
`endif

endmodule
